// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory port, pipeline control inputs
// and the {pc, instr} valid/ready stream toward decode.
interface instr_fetch_unit_if;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        halt_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_pc_o;
    logic [31:0] out_instr_o;

    modport master (
        output imem_addr_o, out_valid_o, out_pc_o, out_instr_o,
        input  imem_instr_i, halt_i, redirect_valid_i, redirect_pc_i, out_ready_i
    );

    modport slave (
        input  imem_addr_o, out_valid_o, out_pc_o, out_instr_o,
        output imem_instr_i, halt_i, redirect_valid_i, redirect_pc_i, out_ready_i
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, samples the combinational
// instruction memory and buffers {pc, instr} pairs toward decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic                clk_i,
    input logic                rst_i,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      NOP     = 32'h0000_0013;

    logic [31:0]      fetch_pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      buf_pc    [FIFO_DEPTH];
    logic [31:0]      buf_instr [FIFO_DEPTH];

    logic empty;
    logic full;
    logic pop;
    logic push;

    // Target alignment drops the byte-offset bits of the redirect address.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = &{1'b0, bus.redirect_pc_i[1:0]};

    // A full buffer can still accept a fetch when the head leaves this cycle.
    always_comb begin
        empty = (count == '0);
        full  = (count == DEPTH_C);
        pop   = !empty && bus.out_ready_i;
        push  = !bus.redirect_valid_i && !bus.halt_i && (!full || pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (bus.redirect_valid_i) begin
            fetch_pc <= {bus.redirect_pc_i[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                wr_ptr   <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_pc[wr_ptr]    <= fetch_pc;
            buf_instr[wr_ptr] <= bus.imem_instr_i;
        end
    end

    always_comb begin
        bus.imem_addr_o = fetch_pc;
        bus.out_valid_o = !empty;
        bus.out_pc_o    = '0;
        bus.out_instr_o = NOP;
        if (!empty) begin
            bus.out_pc_o    = buf_pc[rd_ptr];
            bus.out_instr_o = buf_instr[rd_ptr];
        end
    end
endmodule
